// File: rtl/mp3_spi_pkg.sv
// mp3_spi_pkg: FSM states, frame constants and frame packing shared by mp3_spi_tx.
package mp3_spi_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_DREQ, SETUP, SHIFT, HOLD, GAP} state_e;
  localparam logic [7:0] SCI_WRITE_OP = 8'h02;
  localparam int SCI_FRAME_BITS = 32;
  localparam int SDI_FRAME_BITS = 8;
  // Frames are left-aligned so the shifter always emits from bit 31.
  function automatic logic [31:0] frame_word(input logic is_cmd, input logic [7:0] addr,
                                             input logic [15:0] data);
    return is_cmd ? {SCI_WRITE_OP, addr, data} : {data[7:0], 24'h0};
  endfunction
endpackage

// File: rtl/mp3_spi_clkgen.sv
// mp3_spi_clkgen: emits one tick every CLK_DIV cycles while enabled; restarts from zero when idle.
module mp3_spi_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = (!en || cnt_q == LAST) ? 8'd0 : cnt_q + 8'd1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
  assign tick = en && cnt_q == LAST;
endmodule

// File: rtl/mp3_spi_tx.sv
// mp3_spi_tx: SCI write / SDI byte serialiser for a VS10xx-style mp3 decoder.
// Define MP3_SPI_DREQ_TIMEOUT_EN to bound the DREQ wait and report overruns on err.
module mp3_spi_tx
  import mp3_spi_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_cmd,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_data,
  input  logic        DREQ,
  output logic        XCS,
  output logic        XDCS,
  output logic        SI,
  output logic        SCLK,
  output logic        busy,
  output logic        err
);
  if (CLK_DIV < 1 || CLK_DIV > 255 || TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("mp3_spi_tx: illegal CLK_DIV or TIMEOUT_CYC");
  end

  state_e      state_q, state_d;
  logic [31:0] sr_q, sr_d;
  logic [4:0]  bits_q, bits_d;
  logic        is_cmd_q, is_cmd_d;
  logic        xcs_q, xcs_d, xdcs_q, xdcs_d, si_q, si_d, sclk_q, sclk_d;
  logic        ready_q, ready_d, busy_q, busy_d;
  logic        dreq_meta_q, dreq_q;
  logic        tick;

  mp3_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q inside {SETUP, SHIFT, HOLD, GAP}),
    .tick (tick)
  );

`ifdef MP3_SPI_DREQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  assign tmo_d = (state_q == WAIT_DREQ) ? tmo_q + 1'b1 : '0;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    bits_d   = bits_q;
    is_cmd_d = is_cmd_q;
    xcs_d    = xcs_q;
    xdcs_d   = xdcs_q;
    si_d     = si_q;
    sclk_d   = sclk_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
`ifdef MP3_SPI_DREQ_TIMEOUT_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (req_valid && ready_q) begin
          state_d  = WAIT_DREQ;
          sr_d     = frame_word(req_is_cmd, req_addr, req_data);
          is_cmd_d = req_is_cmd;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
`ifdef MP3_SPI_DREQ_TIMEOUT_EN
          err_d    = 1'b0;
`endif
        end
      end
      WAIT_DREQ: begin
        if (dreq_q) begin
          state_d = SETUP;
          xcs_d   = !is_cmd_q;
          xdcs_d  = is_cmd_q;
          si_d    = sr_q[31];
          sclk_d  = 1'b0;
          bits_d  = is_cmd_q ? 5'(SCI_FRAME_BITS - 1) : 5'(SDI_FRAME_BITS - 1);
        end
`ifdef MP3_SPI_DREQ_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end
`endif
      end
      SETUP: if (tick) begin
        state_d = SHIFT;
        sclk_d  = 1'b1;
      end
      // A tick with SCLK high is a falling edge: next bit goes out, or the frame ends.
      SHIFT: if (tick) begin
        sclk_d = !sclk_q;
        if (sclk_q && bits_q == 5'd0) state_d = HOLD;
        else if (sclk_q) begin
          sr_d   = {sr_q[30:0], 1'b0};
          si_d   = sr_q[30];
          bits_d = bits_q - 5'd1;
        end
      end
      HOLD: if (tick) begin
        state_d = GAP;
        xcs_d   = 1'b1;
        xdcs_d  = 1'b1;
        si_d    = 1'b0;
      end
      GAP: if (tick) begin
        state_d = IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      bits_q      <= '0;
      is_cmd_q    <= 1'b0;
      xcs_q       <= 1'b1;
      xdcs_q      <= 1'b1;
      si_q        <= 1'b0;
      sclk_q      <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      dreq_meta_q <= 1'b0;
      dreq_q      <= 1'b0;
`ifdef MP3_SPI_DREQ_TIMEOUT_EN
      tmo_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bits_q      <= bits_d;
      is_cmd_q    <= is_cmd_d;
      xcs_q       <= xcs_d;
      xdcs_q      <= xdcs_d;
      si_q        <= si_d;
      sclk_q      <= sclk_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      dreq_meta_q <= DREQ;
      dreq_q      <= dreq_meta_q;
`ifdef MP3_SPI_DREQ_TIMEOUT_EN
      tmo_q       <= tmo_d;
      err_q       <= err_d;
`endif
    end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign XCS       = xcs_q;
  assign XDCS      = xdcs_q;
  assign SI        = si_q;
  assign SCLK      = sclk_q;
endmodule

// File: tb/tb_mp3_spi_tx.sv
// tb_mp3_spi_tx: directed + randomized bench; a line monitor records SI at each SCLK rise and the
// expected frame is rebuilt from the request fields alone.
`timescale 1ns/1ps
module tb_mp3_spi_tx;
  localparam int CLK_DIV = 2;
  localparam int TMO     = 100;

  typedef struct packed {logic si; logic xcs; logic xdcs;} rise_t;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_is_cmd, DREQ;
  logic [7:0]  req_addr;
  logic [15:0] req_data;
  logic        req_ready, XCS, XDCS, SI, SCLK, busy, err;

  int    vectors, miscompares;
  rise_t rises[$];
  int    gaps[$];
  int    overlap = 0;
  int    hi_run = 1000;
  logic  prev_sclk = 1'b0;
  logic  prev_cs = 1'b0;

  mp3_spi_tx #(.CLK_DIV(CLK_DIV), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_cmd(req_is_cmd), .req_addr(req_addr), .req_data(req_data), .DREQ(DREQ),
    .XCS(XCS), .XDCS(XDCS), .SI(SI), .SCLK(SCLK), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Serial-line monitor: SI per SCLK rise, chip-select overlap, idle run length before each CS assertion.
  always @(negedge clk) begin : mon
    logic cs;
    cs = (XCS === 1'b0) || (XDCS === 1'b0);
    if (SCLK === 1'b1 && prev_sclk !== 1'b1) rises.push_back('{SI, XCS, XDCS});
    if (XCS === 1'b0 && XDCS === 1'b0) overlap++;
    if (cs && !prev_cs) gaps.push_back(hi_run);
    hi_run = cs ? 0 : hi_run + 1;
    prev_sclk = SCLK;
    prev_cs = cs;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int lim);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (req_ready !== 1'b1 && n < lim);
    check("ready_wait", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic send(input logic cmd, input logic [7:0] a, input logic [15:0] d);
    wait_ready(5000);
    req_is_cmd = cmd;
    req_addr   = a;
    req_data   = d;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_is_cmd = 1'($urandom);
    req_addr   = 8'($urandom);
    req_data   = 16'($urandom);
  endtask

  task automatic expect_frame(input string tag, input logic cmd, input logic [7:0] a,
                              input logic [15:0] d, input int base);
    int n, bad;
    logic [31:0] got, want;
    wait_ready(5000);
    n = rises.size() - base;
    got = '0;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      got = {got[30:0], rises[base+i].si};
      if (rises[base+i].xcs !== ~cmd || rises[base+i].xdcs !== cmd) bad++;
    end
    want = cmd ? {8'h02, a, d} : {24'h0, d[7:0]};
    check({tag, "_nbits"}, 32'(n), cmd ? 32'd32 : 32'd8);
    check({tag, "_word"}, got, want);
    check({tag, "_cs"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int base, cnt, g0, bad, n, mn;
    logic c;
    logic [7:0] a;
    logic [7:0] bb[3];
    logic [15:0] d;
    logic [31:0] got;
    vectors = 0;
    miscompares = 0;
    rst = 1'b0; req_valid = 1'b0; req_is_cmd = 1'b0; req_addr = '0; req_data = '0; DREQ = 1'b1;
    #12;
    check("rst_xcs",   {31'd0, XCS},  32'd1);
    check("rst_xdcs",  {31'd0, XDCS}, 32'd1);
    check("rst_sclk",  {31'd0, SCLK}, 32'd0);
    check("rst_si",    {31'd0, SI},   32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_err",   {31'd0, err},  32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("ready_first_edge", {31'd0, req_ready}, 32'd1);

    base = rises.size(); send(1'b1, 8'h0B, 16'h2020);
    expect_frame("sci_0b2020", 1'b1, 8'h0B, 16'h2020, base);
    base = rises.size(); send(1'b0, 8'h00, 16'h00A5);
    expect_frame("sdi_a5", 1'b0, 8'h00, 16'h00A5, base);
    check("sdi_a5_ready", {31'd0, req_ready}, 32'd1);

    repeat (8) begin
      c = 1'($urandom); a = 8'($urandom); d = 16'($urandom);
      base = rises.size(); send(c, a, d);
      expect_frame("rand", c, a, d, base);
    end

    // DREQ low at acceptance; then DREQ drops again mid-frame, which must not abort.
    DREQ = 1'b0; repeat (3) @(negedge clk);
    c = 1'b1; a = 8'($urandom); d = 16'($urandom);
    base = rises.size(); send(c, a, d);
    cnt = 0;
    repeat (50) begin @(negedge clk); if (XCS !== 1'b1 || XDCS !== 1'b1) cnt++; end
    check("dreq_low_no_cs", 32'(cnt), 32'd0);
    check("dreq_low_busy", {31'd0, busy}, 32'd1);
    @(negedge clk); DREQ = 1'b1; cnt = 0;
    while (XCS === 1'b1 && XDCS === 1'b1 && cnt < 20) begin @(posedge clk); #1; cnt++; end
    check("dreq_sync_latency", {31'd0, cnt >= 3 && cnt < 20}, 32'd1);
    DREQ = 1'b0;
    expect_frame("dreq_drop", c, a, d, base);
    DREQ = 1'b1; repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of an SCI frame.
    base = rises.size(); send(1'b1, 8'h3C, 16'hBEEF);
    cnt = 0;
    while (rises.size() < base + 10 && cnt < 2000) begin @(negedge clk); cnt++; end
    check("reached_bit10", {31'd0, rises.size() >= base + 10}, 32'd1);
    @(posedge clk); #2 rst = 1'b0; #1;
    check("arst_xcs",   {31'd0, XCS},  32'd1);
    check("arst_xdcs",  {31'd0, XDCS}, 32'd1);
    check("arst_sclk",  {31'd0, SCLK}, 32'd0);
    check("arst_si",    {31'd0, SI},   32'd0);
    check("arst_busy",  {31'd0, busy}, 32'd0);
    check("arst_ready", {31'd0, req_ready}, 32'd0);
    repeat (3) @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("arst_ready_after", {31'd0, req_ready}, 32'd1);
    base = rises.size(); send(1'b1, 8'h0B, 16'h1234);
    expect_frame("post_reset", 1'b1, 8'h0B, 16'h1234, base);

    // Back-to-back SDI bytes with req_valid held; data moves on right after each acceptance.
    for (int k = 0; k < 3; k++) bb[k] = 8'($urandom);
    g0 = gaps.size(); base = rises.size();
    wait_ready(5000);
    req_is_cmd = 1'b0; req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_data = {8'($urandom), bb[k]};
      cnt = 0;
      while (req_ready !== 1'b1 && cnt < 5000) begin @(negedge clk); cnt++; end
      @(posedge clk); @(negedge clk);
    end
    req_valid = 1'b0;
    wait_ready(5000);
    n = rises.size() - base; got = '0; bad = 0;
    for (int i = 0; i < n; i++) begin
      got = {got[30:0], rises[base+i].si};
      if (rises[base+i].xcs !== 1'b1 || rises[base+i].xdcs !== 1'b0) bad++;
    end
    check("b2b_nbits", 32'(n), 32'd24);
    check("b2b_word", got, {8'h00, bb[0], bb[1], bb[2]});
    check("b2b_cs", 32'(bad), 32'd0);
    check("b2b_ngaps", 32'(gaps.size() - g0), 32'd3);
    mn = 1000;
    for (int i = g0; i < gaps.size(); i++) if (gaps[i] < mn) mn = gaps[i];
    check("b2b_min_gap", {31'd0, mn >= CLK_DIV}, 32'd1);

    // DREQ held low for longer than the timeout.
    DREQ = 1'b0; repeat (3) @(negedge clk);
    base = rises.size(); send(1'b0, 8'h00, 16'h005A);
`ifdef MP3_SPI_DREQ_TIMEOUT_EN
    repeat (98) @(negedge clk);
    check("tmo_err_early", {31'd0, err}, 32'd0);
    repeat (4) @(negedge clk);
    check("tmo_err_set", {31'd0, err}, 32'd1);
    check("tmo_idle_ready", {31'd0, req_ready}, 32'd1);
    check("tmo_idle_busy", {31'd0, busy}, 32'd0);
    check("tmo_no_bits", 32'(rises.size() - base), 32'd0);
    DREQ = 1'b1; repeat (3) @(negedge clk);
    base = rises.size(); send(1'b1, 8'h55, 16'hA00F);
    check("tmo_err_cleared", {31'd0, err}, 32'd0);
    expect_frame("after_tmo", 1'b1, 8'h55, 16'hA00F, base);
`else
    repeat (150) @(negedge clk);
    check("notmo_err", {31'd0, err}, 32'd0);
    check("notmo_busy", {31'd0, busy}, 32'd1);
    check("notmo_ready", {31'd0, req_ready}, 32'd0);
    DREQ = 1'b1;
    expect_frame("late_dreq", 1'b0, 8'h00, 16'h005A, base);
`endif

    check("cs_overlap", 32'(overlap), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
